// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment scan controller.
// Phase enum, nibble type and the digit-suppression helper.
package seven_seg_pkg;

  localparam int SEG_MAX_DIGITS = 8;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    DEAD,
    ON
  } phase_e;

  function automatic logic seg_dark(
    input nibble_t i_nib,
    input logic    i_dp
  );
    return (i_nib == 4'h0) && !i_dp;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_tick.sv
// Slot counter for the scanner: counts 0..DIV-1 per digit slot.
// Flags describe the cycle after the next edge so outputs can be registered.
module scan_tick_gen
  import seven_seg_pkg::*;
#(
  parameter int DIV         = 10,
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_advance,
  output logic o_slot_start,
  output logic o_slot_last,
  output logic o_in_dead
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  assign o_advance = (r_cnt == C_LAST);
  assign w_cnt_nxt = o_advance ? '0 : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_slot_start = (w_cnt_nxt == '0);
  assign o_slot_last  = (w_cnt_nxt == C_LAST);
  assign o_in_dead    = (w_cnt_nxt < C_DEAD);

endmodule

// File: rtl/seven_seg_scanner.sv
// Double-buffered scan controller for common-anode 7-seg digits.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_HZ      = 100_000_000,
  parameter int SLOT_HZ     = 8_000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [3:0]              digit_data,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int DIV = CLK_HZ / SLOT_HZ;
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  if (DIV < DEAD_CYCLES + 2) begin : g_bad_div
    $error("seven_seg_scanner: DIV must be >= DEAD_CYCLES+2");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > SEG_MAX_DIGITS) begin : g_bad_n
    $error("seven_seg_scanner: NUM_DIGITS must be 2..8");
  end

  logic w_adv;
  logic w_slot_start;
  logic w_slot_last;
  logic w_in_dead;

  scan_tick_gen #(
    .DIV         (DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_advance    (w_adv),
    .o_slot_start (w_slot_start),
    .o_slot_last  (w_slot_last),
    .o_in_dead    (w_in_dead)
  );

  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idx_nxt;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [4*NUM_DIGITS-1:0] w_val_nxt;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   w_dp_nxt;
  logic                    r_pend_v;
  logic                    w_apply;
  logic [NUM_DIGITS-1:0]   w_blank;
  phase_e                  w_ph_nxt;
  logic                    w_show;
  nibble_t                 w_nib;

  logic [NUM_DIGITS-1:0] r_an_n;
  logic [3:0]            r_digit;
  logic                  r_dp_n;
  logic                  r_frame_done;

  assign w_wrap    = w_adv && (r_idx == LAST_IDX);
  assign w_idx_nxt = !w_adv ? r_idx : (w_wrap ? '0 : r_idx + 1'b1);

  // Next-cycle view of the display buffer, so new data lands with slot 0.
  assign w_apply   = w_wrap && r_pend_v;
  assign w_val_nxt = w_apply ? r_pend_val : r_disp_val;
  assign w_dp_nxt  = w_apply ? r_pend_dp : r_disp_dp;

`ifdef SEVEN_SEG_LZB_EN
  always_comb begin : p_lzb
    logic l_run;
    w_blank = '0;
    l_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      l_run      = l_run && seg_dark(w_val_nxt[4*i +: 4], w_dp_nxt[i]);
      w_blank[i] = l_run;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_ph_nxt = w_in_dead ? DEAD : ON;
  assign w_show   = (w_ph_nxt == ON) && digit_en[w_idx_nxt] &&
                    !w_blank[w_idx_nxt];
  assign w_nib    = w_val_nxt[w_idx_nxt*4 +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_v     <= 1'b0;
      r_an_n       <= '1;
      r_digit      <= '0;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_idx <= w_idx_nxt;
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_mask;
        r_pend_v   <= 1'b1;
      end else if (w_apply) begin
        r_pend_v   <= 1'b0;
      end
      if (w_apply) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
      end
      if (w_slot_start) begin
        r_digit <= w_nib;
      end
      r_an_n       <= w_show ? ~(NUM_DIGITS'(1) << w_idx_nxt) : '1;
      r_dp_n       <= w_show ? ~w_dp_nxt[w_idx_nxt] : 1'b1;
      r_frame_done <= w_slot_last && (w_idx_nxt == LAST_IDX);
    end
  end

  assign an_n       = r_an_n;
  assign digit_data = r_digit;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: 4 digits, 10 clocks/slot, 2 dead.
// Frame-level reference model, directed and random stimulus.
module tb_seven_seg_scanner;

`ifdef SEVEN_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  an_n;
  logic [3:0]  digit_data;
  logic        dp_n;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int t     = 0;

  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic [3:0]  m_dpd;
  logic [3:0]  m_dpp;
  logic [3:0]  en_prev;
  logic [3:0]  cur_en;
  bit          m_pv;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (4),
    .CLK_HZ      (80_000),
    .SLOT_HZ     (8_000),
    .DEAD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_mask    (dp_mask),
    .digit_en   (digit_en),
    .load       (load),
    .an_n       (an_n),
    .digit_data (digit_data),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  // Digit d is dark when it and everything above it is zero with no dp.
  function automatic bit blanked(input int d);
    return LZB && (d > 0) && ((m_disp >> (4 * d)) == 16'h0) &&
           ((m_dpd >> d) == 4'h0);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int         slot;
    int         ph;
    bit         show;
    logic [3:0] e_an;
    logic       e_dp;
    logic [3:0] e_nib;
    slot  = (t / 10) % 4;
    ph    = t % 10;
    show  = (ph >= 2) && en_prev[slot] && !blanked(slot);
    e_an  = show ? ~(4'b0001 << slot) : 4'hF;
    e_dp  = show ? ~m_dpd[slot] : 1'b1;
    e_nib = m_disp[slot*4 +: 4];
    chk("an_n", {4'h0, an_n}, {4'h0, e_an});
    chk("dp_n", {7'h0, dp_n}, {7'h0, e_dp});
    chk("digit_data", {4'h0, digit_data}, {4'h0, e_nib});
    chk("frame_done", {7'h0, frame_done}, {7'h0, (t % 40) == 39});
  endtask

  task automatic cyc(input bit ld, input logic [15:0] v,
                     input logic [3:0] dp, input logic [3:0] en);
    check_cycle();
    load     = ld;
    value    = v;
    dp_mask  = dp;
    digit_en = en;
    if ((t % 40) == 39 && m_pv) begin
      m_disp = m_pend;
      m_dpd  = m_dpp;
      m_pv   = 1'b0;
    end
    if (ld) begin
      m_pend = v;
      m_dpp  = dp;
      m_pv   = 1'b1;
    end
    en_prev = en;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, value, dp_mask, cur_en);
  endtask

  task automatic upto(input int p);
    while ((t % 40) != p) cyc(1'b0, value, dp_mask, cur_en);
  endtask

  task automatic ld(input logic [15:0] v, input logic [3:0] dp);
    cyc(1'b1, v, dp, cur_en);
  endtask

  task automatic model_reset();
    m_disp  = '0;
    m_pend  = '0;
    m_dpd   = '0;
    m_dpp   = '0;
    m_pv    = 1'b0;
    en_prev = digit_en;
    t       = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp_mask  = '0;
    cur_en   = 4'hF;
    digit_en = cur_en;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_reset();
    idle(80);

    ld(16'h1234, 4'h0);
    upto(39);
    idle(41);

    upto(15);
    ld(16'hABCD, 4'h0);
    upto(39);
    idle(41);

    upto(5);
    ld(16'h5555, 4'h0);
    idle(3);
    ld(16'h6666, 4'h0);
    upto(39);
    idle(41);

    cur_en = 4'b0101;
    idle(80);
    cur_en = 4'hF;

    ld(16'h1234, 4'b0010);
    upto(39);
    idle(41);

    ld(16'h0050, 4'h0);
    upto(39);
    idle(41);
    ld(16'h0000, 4'h0);
    upto(39);
    idle(41);
    ld(16'h0000, 4'b0100);
    upto(39);
    idle(41);

    upto(38);
    ld(16'h9876, 4'h1);
    ld(16'h1111, 4'h8);
    idle(81);

    repeat (800) begin
      if ($urandom_range(0, 9) == 0) cur_en = 4'($urandom);
      cyc($urandom_range(0, 19) == 0, 16'($urandom), 4'($urandom), cur_en);
    end

    cur_en = 4'hF;
    ld(16'h4321, 4'h2);
    upto(39);
    idle(41);
    upto(25);
    rst_n = 1'b0;
    #1;
    chk("rst_an_n", {4'h0, an_n}, 8'h0F);
    chk("rst_dp_n", {7'h0, dp_n}, 8'h01);
    chk("rst_frame_done", {7'h0, frame_done}, 8'h00);
    chk("rst_digit_data", {4'h0, digit_data}, 8'h00);
    load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_reset();
    idle(120);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It sits directly upstream of the team's 4-bit-to-segment decoder. Each scan slot it presents one digit's nibble on `digit_data` for the decoder to convert, and it drives the active-low anode lines and the decimal point. New display values are double-buffered and applied only at frame boundaries, so the display never tears.

## Interface
- `NUM_DIGITS`, 8: number of multiplexed digits (2..8).
- `CLK_HZ`, 100_000_000: input clock frequency.
- `SLOT_HZ`, 8_000: digit-slot rate. `DIV = CLK_HZ/SLOT_HZ` clocks per slot.
- `DEAD_CYCLES`, 16: anode-off guard at the start of every slot. Elaboration error unless `DIV >= DEAD_CYCLES+2`.
- `clk  in  1`: system clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `value  in  4*NUM_DIGITS`: nibble per digit; digit 0 is bits [3:0].
- `dp_mask  in  NUM_DIGITS`: 1 = light the decimal point of that digit.
- `digit_en  in  NUM_DIGITS`: 1 = digit may be lit.
- `load  in  1`: single-cycle pulse that captures `value` and `dp_mask` into the pending buffer.
- `an_n  out  NUM_DIGITS`: anode enables, active low.
- `digit_data  out  4`: nibble for the decoder.
- `dp_n  out  1`: decimal point, active low.
- `frame_done  out  1`: one-cycle pulse at frame wrap.

## Operation
- Slot counter `cnt` counts 0..DIV-1.
  - When `cnt==DIV-1`, `cnt` returns to 0 and digit index `idx` advances.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Slot phases:
  - DEAD phase (`cnt < DEAD_CYCLES`): `an_n` all 1, `dp_n=1`.
  - ON phase (remaining cycles): `an_n[idx]=0` if the digit is lit, otherwise all anodes stay 1.
  - `dp_n` equals `~disp_dp[idx]` during ON, gated by the same lit condition.
- `digit_data` updates only when a slot starts, i.e. inside the DEAD phase, so the decoder output settles before the anode turns on.
- Double buffer:
  - `load` writes the pending register and sets `pend_v`.
  - A second `load` before the frame wrap overwrites the pending data; the last write wins.
  - At the frame wrap (`idx` NUM_DIGITS-1 to 0), if `pend_v` is set, the display register takes the pending data and `pend_v` clears.
  - If `load` arrives in the same cycle as the wrap, that data goes to pending only and is applied at the next wrap.
- Frame timing:
  - `frame_done` pulses during the cycle in which `idx` wraps.
  - One frame is exactly `NUM_DIGITS*DIV` cycles, regardless of `digit_en`.
  - A disabled slot is still consumed, so brightness stays uniform.
- `digit_en` is sampled live, without buffering.
- Lit condition: `digit_en[idx]`, AND not blanked (see Configuration).

## Timing
- Reset values:
  - `an_n` all 1, `dp_n=1`, `digit_data=0`, `frame_done=0`.
  - `cnt=0`, `idx=0`, display and pending registers 0, `pend_v=0`.
- Reset mid-slot takes effect immediately and asynchronously. After release, scanning restarts at digit 0, DEAD phase.
- All outputs are registered.
- Latency from `load` to visible data: the next frame wrap, at most `NUM_DIGITS*DIV` cycles later.

## Configuration
- `SEVEN_SEG_LZB_EN` defined: leading-zero blanking.
  - Starting from digit NUM_DIGITS-1 and moving down, a digit is blanked while its display nibble is 0 and every more significant digit is also blanked.
  - A digit with its `dp` bit set stops the suppression.
  - Digit 0 is never blanked.
  - The blank mask is computed from the display register and is stable for the whole frame.
- Undefined: no blanking; the lit condition is `digit_en[idx]` only.

## Structure
- Shared package `seven_seg_pkg`:
  - `SEG_MAX_DIGITS=8`.
  - `typedef logic [3:0] nibble_t`.
  - Phase enum `{DEAD, ON}`.
- One sub-module, `scan_tick_gen`: the slot counter. Outputs `slot_start`, `slot_last` and `in_dead`. Parameterized by `DIV` and `DEAD_CYCLES`.
- The decoder is instantiated beside this block by the parent, not inside it.

## Test plan
Bench parameters: NUM_DIGITS=4, DIV=10, DEAD_CYCLES=2.
- Reset: assert `rst_n=0` mid ON phase -> `an_n=4'hF`, `dp_n=1`, `frame_done=0` within the same cycle. After release, the first ON phase is digit 0 at cycle 2.
- Basic scan: `load` 16'h1234, wait for `frame_done` -> digit-0 slot shows `digit_data=4`, `an_n=4'hF` in cycles 0-1 and `4'b1110` in cycles 2-9; digits 1..3 show 3, 2, 1.
- Tear-free update: while 1234 is displayed, `load` 16'hABCD in the digit-1 slot -> digits 2 and 3 still show 2 and 1; A/B/C/D appears only after the next `frame_done`. `load` 5555 then 6666 in the same frame -> 6666 shown.
- Enables: `digit_en=4'b0101` -> `an_n[1]` and `an_n[3]` are never 0; `frame_done` period stays 40 cycles.
- Decimal point: `dp_mask=4'b0010` -> `dp_n=0` only in digit-1 ON cycles 2-9.
- LZB (`SEVEN_SEG_LZB_EN` defined):
  - 16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0.
  - 16'h0000 -> only digit 0 lit.
  - 16'h0000 with `dp_mask=4'b0100` -> digits 2..0 lit.
  - Macro undefined -> all four lit.
